// File: rtl/button_grant_arbiter.sv
// Round-robin arbiter sharing one slow-clock output stage between N push buttons.
// Buttons are synchronized, edge-detected into pending requests, then granted for HOLD ticks each.
module button_grant_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned OW   = 2,
  parameter int unsigned HOLD = 3
) (
  input  logic          CLK_1hz,
  input  logic          rst,
  input  logic [N-1:0]  req_in,
  output logic [N-1:0]  grant,
  output logic [OW-1:0] owner,
  output logic          busy,
  output logic [N-1:0]  pending,
  output logic [7:0]    served_count
);

  localparam int unsigned TW = 4;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [N-1:0]  s1, s2, prev;
  logic [N-1:0]  rise_c, clr_c, pending_nxt;
  logic [N-1:0]  grant_nxt;
  logic [OW-1:0] owner_nxt, winner_c, scan_idx_c;
  logic          winner_found_c;
  logic          busy_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [7:0]    served_nxt;

  assign rise_c = s2 & ~prev;

  // First pending requester after the previous owner, wrapping around.
  always_comb begin
    winner_c       = owner;
    winner_found_c = 1'b0;
    scan_idx_c     = owner;
    for (int k = 1; k <= int'(N); k++) begin
      scan_idx_c = OW'((int'(owner) + k) % int'(N));
      if (!winner_found_c && pending[scan_idx_c]) begin
        winner_c       = scan_idx_c;
        winner_found_c = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    owner_nxt  = owner;
    busy_nxt   = busy;
    timer_nxt  = timer;
    served_nxt = served_count;
    clr_c      = '0;
    case (state)
      IDLE: begin
        if (winner_found_c) begin
          grant_nxt           = '0;
          grant_nxt[winner_c] = 1'b1;
          clr_c[winner_c]     = 1'b1;
          owner_nxt           = winner_c;
          busy_nxt            = 1'b1;
          timer_nxt           = HOLD_LOAD;
          served_nxt          = served_count + 8'd1;
          state_nxt           = GRANT;
        end
      end
      GRANT: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else begin
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    // A fresh rising edge wins over the clear of the same bit.
    pending_nxt = (pending & ~clr_c) | rise_c;
  end

  always_ff @(posedge CLK_1hz) begin
    if (!rst) begin
      s1           <= '0;
      s2           <= '0;
      prev         <= '0;
      pending      <= '0;
      grant        <= '0;
      owner        <= OW'(N - 1);
      busy         <= 1'b0;
      timer        <= '0;
      served_count <= '0;
      state        <= IDLE;
    end else begin
      s1           <= req_in;
      s2           <= s1;
      prev         <= s2;
      pending      <= pending_nxt;
      grant        <= grant_nxt;
      owner        <= owner_nxt;
      busy         <= busy_nxt;
      timer        <= timer_nxt;
      served_count <= served_nxt;
      state        <= state_nxt;
    end
  end

endmodule

// File: tb/tb_button_grant_arbiter.sv
// Bench for button_grant_arbiter: cycle model feeds a scoreboard queue, plus directed spot checks.
module tb_button_grant_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned OW   = 2;
  localparam int unsigned HOLD = 3;

  logic          CLK_1hz = 1'b0;
  logic          rst;
  logic [N-1:0]  req_in;
  logic [N-1:0]  grant;
  logic [OW-1:0] owner;
  logic          busy;
  logic [N-1:0]  pending;
  logic [7:0]    served_count;

  button_grant_arbiter #(.N(N), .OW(OW), .HOLD(HOLD)) dut (
    .CLK_1hz      (CLK_1hz),
    .rst          (rst),
    .req_in       (req_in),
    .grant        (grant),
    .owner        (owner),
    .busy         (busy),
    .pending      (pending),
    .served_count (served_count)
  );

  always #5 CLK_1hz = ~CLK_1hz;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] o;
    logic       b;
    logic [3:0] p;
    logic [7:0] s;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: phase 0 idle, 1 granting, 2 release gap.
  logic [3:0] m_s1, m_s2, m_prev, m_pend, m_grant;
  logic [1:0] m_owner;
  logic       m_busy;
  logic [7:0] m_served;
  int         m_left;
  int         m_phase;
  int         m_grants = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic rv);
    logic [3:0] rise;
    logic [3:0] taken;
    int         idx;
    if (!rv) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_pend = '0; m_grant = '0;
      m_owner = 2'd3; m_busy = 1'b0; m_served = '0; m_left = 0; m_phase = 0;
      return;
    end
    rise  = m_s2 & ~m_prev;
    taken = '0;
    if (m_phase == 0) begin
      if (m_pend != 0) begin
        for (int k = 1; k <= 4; k++) begin
          idx = (int'(m_owner) + k) % 4;
          if (taken == 0 && m_pend[idx]) taken[idx] = 1'b1;
        end
        for (int i = 0; i < 4; i++) if (taken[i]) m_owner = 2'(i);
        m_grant  = taken;
        m_busy   = 1'b1;
        m_left   = HOLD - 1;
        m_served = m_served + 8'd1;
        m_grants++;
        m_phase  = 1;
      end
    end else if (m_phase == 1) begin
      if (m_left > 0) m_left--;
      else begin
        m_grant = '0;
        m_busy  = 1'b0;
        m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
    m_pend = (m_pend & ~taken) | rise;
    m_prev = m_s2;
    m_s2   = m_s1;
    m_s1   = r;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare once the DUT has clocked it.
  task automatic tick(input logic [3:0] r, input logic rv);
    exp_t e;
    exp_t x;
    req_in = r;
    rst    = rv;
    model_step(r, rv);
    e.g = m_grant; e.o = m_owner; e.b = m_busy; e.p = m_pend; e.s = m_served;
    sb.push_back(e);
    @(posedge CLK_1hz);
    #1;
    x = sb.pop_front();
    chk("grant", 32'(grant), 32'(x.g));
    chk("owner", 32'(owner), 32'(x.o));
    chk("busy", 32'(busy), 32'(x.b));
    chk("pending", 32'(pending), 32'(x.p));
    chk("served", 32'(served_count), 32'(x.s));
    chk("onehot0", 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic do_reset();
    repeat (2) tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);
  endtask

  initial begin
    int g0;
    int c;
    req_in = 4'b1111;
    rst    = 1'b0;

    // Reset with all buttons held
    repeat (3) tick(4'b1111, 1'b0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_owner", 32'(owner), 32'd3);
    chk("rst_served", 32'(served_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) tick(4'b0000, 1'b1);

    // Single held press
    for (int t = 1; t <= 15; t++) begin
      tick(4'b0010, 1'b1);
      if (t == 3) chk("sp_pend", 32'(pending), 32'h2);
      if (t == 4) chk("sp_clr", 32'(pending), 32'h0);
      if (t >= 4 && t <= 6) chk("sp_grant", 32'(grant), 32'h2);
      if (t == 7) chk("sp_busy_fall", 32'(busy), 32'd0);
      if (t >= 7) chk("sp_no_regrant", 32'(grant), 32'h0);
    end
    chk("sp_served", 32'(served_count), 32'd1);

    // Simultaneous presses from reset
    do_reset();
    for (int t = 1; t <= 14; t++) begin
      tick(4'b0101, 1'b1);
      if (t >= 4 && t <= 6) chk("sim_first", 32'(grant), 32'h1);
      if (t == 7 || t == 8) chk("sim_gap", 32'(grant), 32'h0);
      if (t >= 9 && t <= 11) chk("sim_second", 32'(grant), 32'h4);
    end
    chk("sim_served", 32'(served_count), 32'd2);

    // Round-robin after owner 1 with 0 and 3 pending
    do_reset();
    for (int t = 1; t <= 16; t++) begin
      tick((t < 5) ? 4'b0010 : 4'b1011, 1'b1);
      if (t == 4) chk("rr_g1", 32'(grant), 32'h2);
      if (t == 7) chk("rr_pend", 32'(pending), 32'h9);
      if (t == 9) chk("rr_g3", 32'(grant), 32'h8);
      if (t == 14) chk("rr_g0", 32'(grant), 32'h1);
    end

    // Owner re-presses during its own grant
    do_reset();
    for (int t = 1; t <= 12; t++) begin
      tick((t == 3) ? 4'b0000 : 4'b0100, 1'b1);
      if (t == 6) chk("rp_pend", 32'(pending), 32'h4);
      if (t == 6) chk("rp_grant", 32'(grant), 32'h4);
      if (t == 9) chk("rp_regrant", 32'(grant), 32'h4);
    end

    // Reset during the second grant cycle
    do_reset();
    for (int t = 1; t <= 5; t++) begin
      tick(4'b0001, 1'b1);
      if (t == 4) chk("mr_grant", 32'(grant), 32'h1);
    end
    tick(4'b0001, 1'b0);
    chk("mr_grant0", 32'(grant), 32'h0);
    chk("mr_busy0", 32'(busy), 32'd0);
    chk("mr_owner", 32'(owner), 32'd3);
    chk("mr_pend0", 32'(pending), 32'h0);
    repeat (6) tick(4'b0001, 1'b1);

    // 256 grants wrap the served counter
    do_reset();
    g0 = m_grants;
    c  = 0;
    while (c < 4000 && (m_grants - g0) < 256) begin
      tick((((c / 4) % 2) == 1) ? 4'b1111 : 4'b0000, 1'b1);
      c++;
    end
    chk("wrap_count", 32'(m_grants - g0), 32'd256);
    chk("wrap_served", 32'(served_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
